pwm_btn_ctrl: RTL and testbench
===============================

# pwm_btn_ctrl

Multi-channel, button-driven PWM controller. It is the parametrised successor of the single-channel button/PWM test block. Each of CHANNELS channels has its own duty-step button, prescaler button, PWM counter and overflow flag. All logic runs in the single `clk` domain: debouncing uses clock-enable counters, not derived clocks or button-edge clocking. Duty and prescaler changes are shadowed and take effect only at a period boundary, so no PWM period is ever glitched.

## Interface
- CHANNELS, 4, number of independent PWM channels
- DATA_WIDTH, 8, width of duty, prescaler and PWM counter; TOP = 2^DATA_WIDTH-1
- DUTY_STEP, 25, duty increment per debounced press
- DEBOUNCE_CYCLES, 16, consecutive stable synchronised samples required to accept a level change (≥2)
- clk  in  1  system clock
- rst_btn_debounced  in  1  reset, asynchronous, active-high
- duty_btn  in  CHANNELS  raw duty-step buttons, active-high, asynchronous to clk
- psc_btn  in  CHANNELS  raw prescaler buttons, active-high, asynchronous to clk
- out_pwm  out  CHANNELS  registered PWM outputs
- pwm_overflow_flag  out  CHANNELS  one-cycle pulse at each period wrap
- duty_q  out  CHANNELS*DATA_WIDTH  active duty per channel, channel 0 in LSBs
- psc_q  out  CHANNELS*DATA_WIDTH  active prescaler per channel

## Operation
- Button path, per input:
  - 2-flop synchroniser, then a debounce counter.
  - Stable level changes only after DEBOUNCE_CYCLES equal consecutive samples.
  - A 0→1 stable transition emits a one-cycle press pulse.
  - Releases emit nothing.
- Duty press: duty_shadow ← duty_shadow + DUTY_STEP. Wrap or saturate per Configuration.
- Prescaler press: psc_shadow ← 4 if 0, else psc_shadow·4 truncated to DATA_WIDTH. With DATA_WIDTH=8 the sequence is 0→4→16→64→0.
- Prescale counter pc counts 0..psc_active. The tick occurs when pc==psc_active; pc then returns to 0.
- On a tick, cnt increments. When cnt==TOP on a tick:
  - cnt→0;
  - pwm_overflow_flag pulses;
  - duty_active←duty_shadow and psc_active←psc_shadow.
- out_pwm ← (cnt < duty_active), registered.
  - duty_active=0 → constantly low.
  - duty_active=TOP → low for one count per period.
- Period length is 2^DATA_WIDTH·(psc_active+1) clk cycles.
- Multiple presses before a boundary accumulate in the shadow; only the final value is applied.
- Simultaneous duty and psc presses on one channel both apply. Channels are fully independent.

## Timing
- Reset (async assert, sync-safe deassert assumed upstream):
  - out_pwm=0, pwm_overflow_flag=0, duty_q=0, psc_q=0;
  - all shadows, pc, cnt and debounce state = 0 (debounce state = released).
- A button held through reset deassertion is a new press after 2+DEBOUNCE_CYCLES cycles.
- Press latency: the raw rising edge reaches the shadow update 2 (sync) + DEBOUNCE_CYCLES + 1 cycles later. It is visible on duty_q/psc_q at the next overflow pulse.
- pwm_overflow_flag asserts in the cycle after the tick in which cnt==TOP. duty_q/psc_q update in the same cycle.
- out_pwm lags cnt by one cycle.
- First period after reset with psc=0: overflow pulse on cycle 256 (DATA_WIDTH=8), then every 256 cycles.
- Reset mid-period discards pending shadow values. No partial flag pulse is produced.

## Configuration
- PWM_BTN_CTRL_DUTY_SAT_EN defined: the duty increment saturates at TOP. Further presses hold TOP.
- PWM_BTN_CTRL_DUTY_SAT_EN undefined: the duty increment wraps modulo 2^DATA_WIDTH, which is the legacy behaviour.

## Structure
- The shared package pwm_btn_pkg holds:
  - the prescaler multiplier constant (4) and the psc next-value function;
  - the TOP derivation from DATA_WIDTH.
- Sub-module btn_edge_debounce: synchroniser, debounce counter and press-pulse output. It is parametrised by DEBOUNCE_CYCLES and instantiated 2·CHANNELS times.
- Per-channel shadow, prescaler and PWM counter logic sits in a generate loop in pwm_btn_ctrl.

## Test plan
Use CHANNELS=2, DATA_WIDTH=8, DEBOUNCE_CYCLES=4, DUTY_STEP=25.
- Reset, no presses → out_pwm=00, overflow pulse on both channels every 256 cycles, duty_q=psc_q=0.
- Three clean duty_btn[0] presses → duty_q[0]=75 after next overflow; out_pwm[0] high 75 of 256 cycles; channel 1 still 0.
- 3-cycle glitches on duty_btn[1] → no change; a 10-cycle press → duty_q[1]=25.
- Four psc_btn[0] presses → psc_q[0] 4,16,64,0 at successive boundaries; period at psc=4 is 1280 cycles.
- Eleven duty presses → duty_q=255 with PWM_BTN_CTRL_DUTY_SAT_EN; 19 without.
- Assert rst_btn_debounced mid-period with duty=75 pending → all outputs 0 immediately; pending value lost after release.

Source files
------------

// File: rtl/pwm_btn_pkg.sv
// Shared constants, types and helpers for the button-driven PWM controller.
package pwm_btn_pkg;

  localparam int unsigned PSC_MULT = 4;

  typedef enum logic {
    BTN_RELEASED = 1'b0,
    BTN_PRESSED  = 1'b1
  } btn_level_e;

  function automatic logic [31:0] top_of(input int unsigned width);
    return (32'd1 << width) - 32'd1;
  endfunction

  // Prescaler step: 0 jumps to PSC_MULT, otherwise multiply and truncate to width.
  function automatic logic [31:0] psc_next(input logic [31:0] cur, input int unsigned width);
    logic [31:0] prod;
    prod = (cur == 32'd0) ? PSC_MULT : cur * PSC_MULT;
    return prod & top_of(width);
  endfunction

endpackage

// File: rtl/btn_edge_debounce.sv
// Raw button -> 2-flop synchroniser -> debounce counter -> one-cycle press pulse.
module btn_edge_debounce
  import pwm_btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_btn_debounced,
  input  logic i_btn,
  output logic o_press
);

  localparam int unsigned   CW       = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  btn_level_e    r_stable;
  logic          r_press;
  logic          w_sample;

  assign w_sample = r_sync[1];
  assign o_press  = r_press;

  // r_cnt counts consecutive synchronised samples that disagree with r_stable.
  always_ff @(posedge clk or posedge rst_btn_debounced) begin
    if (rst_btn_debounced) begin
      r_sync   <= '0;
      r_cnt    <= '0;
      r_stable <= BTN_RELEASED;
      r_press  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop here sample pre-edge values.
      r_sync  <= {r_sync[0], i_btn};
      r_press <= 1'b0;
      if (w_sample == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt    <= '0;
        r_stable <= btn_level_e'(w_sample);
        r_press  <= w_sample;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/pwm_btn_ctrl.sv
// Multi-channel button-driven PWM with shadowed duty/prescaler applied at period wrap.
// Define PWM_BTN_CTRL_DUTY_SAT_EN to saturate duty at TOP instead of wrapping.
module pwm_btn_ctrl
  import pwm_btn_pkg::*;
#(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned DUTY_STEP       = 25,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                           clk,
  input  logic                           rst_btn_debounced,
  input  logic [CHANNELS-1:0]            duty_btn,
  input  logic [CHANNELS-1:0]            psc_btn,
  output logic [CHANNELS-1:0]            out_pwm,
  output logic [CHANNELS-1:0]            pwm_overflow_flag,
  output logic [CHANNELS*DATA_WIDTH-1:0] duty_q,
  output logic [CHANNELS*DATA_WIDTH-1:0] psc_q
);

  localparam logic [DATA_WIDTH-1:0] TOP = DATA_WIDTH'(top_of(DATA_WIDTH));
`ifdef PWM_BTN_CTRL_DUTY_SAT_EN
  localparam logic [DATA_WIDTH:0]   STEP_EXT = (DATA_WIDTH + 1)'(DUTY_STEP);
`else
  localparam logic [DATA_WIDTH-1:0] STEP     = DATA_WIDTH'(DUTY_STEP);
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic                  w_duty_press, w_psc_press, w_tick, w_wrap;
    logic [DATA_WIDTH-1:0] w_duty_next, w_psc_next;
    logic [DATA_WIDTH-1:0] r_duty_shadow, r_psc_shadow, r_duty_active, r_psc_active;
    logic [DATA_WIDTH-1:0] r_pc, r_cnt;
    logic                  r_pwm, r_ovf;

    btn_edge_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_duty_db (
      .clk               (clk),
      .rst_btn_debounced (rst_btn_debounced),
      .i_btn             (duty_btn[c]),
      .o_press           (w_duty_press)
    );

    btn_edge_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_psc_db (
      .clk               (clk),
      .rst_btn_debounced (rst_btn_debounced),
      .i_btn             (psc_btn[c]),
      .o_press           (w_psc_press)
    );

`ifdef PWM_BTN_CTRL_DUTY_SAT_EN
    logic [DATA_WIDTH:0] w_duty_sum;
    assign w_duty_sum  = {1'b0, r_duty_shadow} + STEP_EXT;
    assign w_duty_next = (w_duty_sum > {1'b0, TOP}) ? TOP : w_duty_sum[DATA_WIDTH-1:0];
`else
    assign w_duty_next = r_duty_shadow + STEP;
`endif
    assign w_psc_next = DATA_WIDTH'(psc_next(32'(r_psc_shadow), DATA_WIDTH));

    assign w_tick = (r_pc == r_psc_active);
    assign w_wrap = w_tick && (r_cnt == TOP);

    // Actives load from the pre-edge shadow, so a press landing on the wrap edge waits a period.
    always_ff @(posedge clk or posedge rst_btn_debounced) begin
      if (rst_btn_debounced) begin
        r_duty_shadow <= '0;
        r_psc_shadow  <= '0;
        r_duty_active <= '0;
        r_psc_active  <= '0;
        r_pc          <= '0;
        r_cnt         <= '0;
        r_pwm         <= 1'b0;
        r_ovf         <= 1'b0;
      end else begin
        r_pc  <= w_tick ? '0 : r_pc + DATA_WIDTH'(1);
        r_ovf <= w_wrap;
        r_pwm <= (r_cnt < r_duty_active);
        if (w_tick) begin
          r_cnt <= w_wrap ? '0 : r_cnt + DATA_WIDTH'(1);
        end
        if (w_wrap) begin
          r_duty_active <= r_duty_shadow;
          r_psc_active  <= r_psc_shadow;
        end
        if (w_duty_press) begin
          r_duty_shadow <= w_duty_next;
        end
        if (w_psc_press) begin
          r_psc_shadow <= w_psc_next;
        end
      end
    end

    assign out_pwm[c]                             = r_pwm;
    assign pwm_overflow_flag[c]                   = r_ovf;
    assign duty_q[c*DATA_WIDTH +: DATA_WIDTH]     = r_duty_active;
    assign psc_q[c*DATA_WIDTH +: DATA_WIDTH]      = r_psc_active;
  end

endmodule

// File: tb/tb_pwm_btn_ctrl.sv
// Self-checking bench for pwm_btn_ctrl: directed table, hand sequences and random buttons vs a reference model.
module tb_pwm_btn_ctrl;

  localparam int CH   = 2;
  localparam int DW   = 8;
  localparam int DB   = 4;
  localparam int STEP = 25;
  localparam int TOPV = 255;
  localparam int NB   = 2 * CH;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [CH-1:0]   duty_btn = '0;
  logic [CH-1:0]   psc_btn  = '0;
  logic [CH-1:0]   out_pwm, ovf;
  logic [CH*DW-1:0] duty_q, psc_q;

  pwm_btn_ctrl #(
    .CHANNELS(CH), .DATA_WIDTH(DW), .DUTY_STEP(STEP), .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk               (clk),
    .rst_btn_debounced (rst),
    .duty_btn          (duty_btn),
    .psc_btn           (psc_btn),
    .out_pwm           (out_pwm),
    .pwm_overflow_flag (ovf),
    .duty_q            (duty_q),
    .psc_q             (psc_q)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input int ch, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s ch%0d: got %0d, expected %0d (t=%0t)", name, ch, act, exp, $time);
    end
  endtask

  // Reference model: period position arithmetic plus a sliding window over raw samples.
  int m_n;
  int m_pos[CH], m_duty_act[CH], m_psc_act[CH], m_duty_sh[CH], m_psc_sh[CH];
  bit m_dpress[CH], m_ppress[CH];
  bit m_lvl[NB];
  bit m_log[NB][64];
  bit e_pwm[CH], e_ovf[CH];

  function automatic int duty_after_press(input int d);
`ifdef PWM_BTN_CTRL_DUTY_SAT_EN
    return (d + STEP > TOPV) ? TOPV : d + STEP;
`else
    return (d + STEP) % (TOPV + 1);
`endif
  endfunction

  function automatic int psc_after_press(input int p);
    return (p == 0) ? 4 : (p * 4) % (TOPV + 1);
  endfunction

  function automatic bit raw_at(input int b, input int m);
    return (m < 1) ? 1'b0 : m_log[b][m % 64];
  endfunction

  task automatic model_reset();
    m_n = 0;
    for (int c = 0; c < CH; c++) begin
      m_pos[c] = 0; m_duty_act[c] = 0; m_psc_act[c] = 0; m_duty_sh[c] = 0; m_psc_sh[c] = 0;
      m_dpress[c] = 0; m_ppress[c] = 0; e_pwm[c] = 0; e_ovf[c] = 0;
    end
    for (int b = 0; b < NB; b++) begin
      m_lvl[b] = 0;
      for (int k = 0; k < 64; k++) m_log[b][k] = 0;
    end
  endtask

  task automatic model_edge();
    m_n++;
    for (int b = 0; b < NB; b++)
      m_log[b][m_n % 64] = (b < CH) ? duty_btn[b] : psc_btn[b-CH];
    for (int c = 0; c < CH; c++) begin
      int per = m_psc_act[c] + 1;
      e_pwm[c] = ((m_pos[c] / per) < m_duty_act[c]);
      e_ovf[c] = 0;
      m_pos[c]++;
      if (m_pos[c] == (TOPV + 1) * per) begin
        e_ovf[c] = 1;
        m_pos[c] = 0;
        m_duty_act[c] = m_duty_sh[c];
        m_psc_act[c]  = m_psc_sh[c];
      end
      if (m_dpress[c]) m_duty_sh[c] = duty_after_press(m_duty_sh[c]);
      if (m_ppress[c]) m_psc_sh[c]  = psc_after_press(m_psc_sh[c]);
    end
    for (int b = 0; b < NB; b++) begin
      bit all_diff = 1;
      bit pr = 0;
      for (int k = 2; k <= DB + 1; k++)
        if (raw_at(b, m_n - k) == m_lvl[b]) all_diff = 0;
      if (all_diff) begin
        m_lvl[b] = !m_lvl[b];
        pr = m_lvl[b];
      end
      if (b < CH) m_dpress[b] = pr;
      else        m_ppress[b-CH] = pr;
    end
  endtask

  task automatic compare_all();
    for (int c = 0; c < CH; c++) begin
      check("out_pwm", c, out_pwm[c], e_pwm[c]);
      check("overflow", c, ovf[c], e_ovf[c]);
      check("duty_q", c, duty_q[c*DW +: DW], m_duty_act[c]);
      check("psc_q", c, psc_q[c*DW +: DW], m_psc_act[c]);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
    end
  endtask

  // Asynchronous assert between edges; outputs must be zero before any further edge.
  task automatic apply_reset();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    compare_all();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic press(input int ch, input bit is_psc, input int hold);
    if (is_psc) psc_btn[ch] = 1'b1; else duty_btn[ch] = 1'b1;
    tick(hold);
    if (is_psc) psc_btn[ch] = 1'b0; else duty_btn[ch] = 1'b0;
    tick(10);
  endtask

  task automatic run_to_ovf(input int ch, input int bound, output int cycles, output int high);
    cycles = 0;
    high   = 0;
    do begin
      tick(1);
      cycles++;
      high += int'(out_pwm[ch]);
    end while (!ovf[ch] && cycles < bound);
  endtask

  typedef struct {
    int ch;
    bit is_psc;
    int presses;
    int exp_duty;
    int exp_psc;
    int exp_period;
    int exp_high;
  } vec_t;

  vec_t vecs[7];
  int   cyc, hi;
  int   hold_left[NB];

  initial begin
    vecs[0] = '{0, 1'b0, 3,  75,  0,  256,  75};
    vecs[1] = '{1, 1'b0, 1,  25,  0,  256,  25};
    vecs[2] = '{0, 1'b1, 1,  75,  4, 1280, 375};
    vecs[3] = '{0, 1'b1, 1,  75, 16,    0,   0};
    vecs[4] = '{0, 1'b1, 1,  75, 64,    0,   0};
    vecs[5] = '{0, 1'b1, 1,  75,  0,  256,  75};
`ifdef PWM_BTN_CTRL_DUTY_SAT_EN
    vecs[6] = '{1, 1'b0, 10, 255, 0,  256, 255};
`else
    vecs[6] = '{1, 1'b0, 10, 19,  0,  256,  19};
`endif

    apply_reset();

    run_to_ovf(0, 400, cyc, hi);
    check("first_ovf_cycle", 0, cyc, 256);
    check("first_ovf_both", 1, ovf[1], 1);
    run_to_ovf(0, 400, cyc, hi);
    check("second_period", 0, cyc, 256);
    check("idle_high_count", 0, hi, 0);

    repeat (4) begin
      duty_btn[1] = 1'b1; tick(3);
      duty_btn[1] = 1'b0; tick(3);
    end
    tick(20);
    run_to_ovf(1, 400, cyc, hi);
    check("glitch_ignored", 1, duty_q[DW +: DW], 0);

    for (int i = 0; i < 7; i++) begin
      repeat (vecs[i].presses) press(vecs[i].ch, vecs[i].is_psc, 10);
      run_to_ovf(vecs[i].ch, 20000, cyc, hi);
      check("tbl_boundary", vecs[i].ch, ovf[vecs[i].ch], 1);
      check("tbl_duty", vecs[i].ch, duty_q[vecs[i].ch*DW +: DW], vecs[i].exp_duty);
      check("tbl_psc", vecs[i].ch, psc_q[vecs[i].ch*DW +: DW], vecs[i].exp_psc);
      if (vecs[i].exp_period != 0) begin
        run_to_ovf(vecs[i].ch, 20000, cyc, hi);
        check("tbl_period", vecs[i].ch, cyc, vecs[i].exp_period);
        check("tbl_high", vecs[i].ch, hi, vecs[i].exp_high);
      end
    end

    for (int b = 0; b < NB; b++) hold_left[b] = 0;
    repeat (4000) begin
      for (int b = 0; b < NB; b++) begin
        if (hold_left[b] == 0) begin
          hold_left[b] = int'($urandom_range(1, 14));
          if (b < CH) duty_btn[b] = 1'($urandom_range(0, 1));
          else        psc_btn[b-CH] = 1'($urandom_range(0, 1));
        end
        hold_left[b]--;
      end
      tick(1);
    end

    duty_btn = '0;
    psc_btn  = '0;
    apply_reset();
    tick(20);
    repeat (3) press(0, 1'b0, 10);
    duty_btn[1] = 1'b1;
    apply_reset();
    run_to_ovf(0, 400, cyc, hi);
    check("post_reset_first_ovf", 0, cyc, 256);
    check("pending_lost", 0, duty_q[0 +: DW], 0);
    check("held_through_reset", 1, duty_q[DW +: DW], 25);
    duty_btn[1] = 1'b0;
    tick(20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
